// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a 32-bit immediate into I/S/B/J fields of a template word.
// Two-stage valid/ready pipeline; define IMMENC_ERRCNT_EN to build the saturating error counter.
module imm_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ImmSel,
  input  logic [31:0]      base_instr,
  input  logic [31:0]      imm_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_out,
  output logic             range_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_J = 2'b11
  } fmt_e;

  logic        s1_valid;
  fmt_e        s1_sel;
  logic [31:0] s1_base;
  logic [31:0] s1_imm;

  logic        s1_load;
  logic        s2_load;
  logic [31:0] packed_word;
  logic        err1;

  // out_valid doubles as the stage-2 valid bit
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !rst && s1_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sel   <= FMT_I;
      s1_base  <= '0;
      s1_imm   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sel  <= fmt_e'(ImmSel);
        s1_base <= base_instr;
        s1_imm  <= imm_in;
      end
    end
  end

  logic sx_11;
  logic sx_12;
  logic sx_20;

  // Sign-extension checks: upper bits must all match the field's top bit
  assign sx_11 = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign sx_12 = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
  assign sx_20 = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

  always_comb begin
    packed_word = s1_base;
    err1        = 1'b0;
    unique case (s1_sel)
      FMT_I: begin
        packed_word[31:20] = s1_imm[11:0];
        err1               = !sx_11;
      end
      FMT_S: begin
        packed_word[31:25] = s1_imm[11:5];
        packed_word[11:7]  = s1_imm[4:0];
        err1               = !sx_11;
      end
      FMT_B: begin
        packed_word[31]    = s1_imm[12];
        packed_word[30:25] = s1_imm[10:5];
        packed_word[11:8]  = s1_imm[4:1];
        packed_word[7]     = s1_imm[11];
        err1               = !sx_12 || s1_imm[0];
      end
      FMT_J: begin
        packed_word[31]    = s1_imm[20];
        packed_word[30:21] = s1_imm[10:1];
        packed_word[20]    = s1_imm[11];
        packed_word[19:12] = s1_imm[19:12];
        err1               = !sx_20 || s1_imm[0];
      end
      default: begin
        packed_word = s1_base;
        err1        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      instr_out <= '0;
      range_err <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        instr_out <= packed_word;
        range_err <= err1;
      end
    end
  end

`ifdef IMMENC_ERRCNT_EN
  logic [CNT_W-1:0] cnt;
  logic             err_fire;

  assign err_fire = out_valid && out_ready && range_err;

  // Clear wins over accumulated count, but a same-cycle erroneous transfer still counts once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (err_clr) begin
      cnt <= err_fire ? CNT_W'(1) : '0;
    end else if (err_fire && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign err_count = cnt;
`else
  logic unused_clr;
  assign unused_clr = err_clr;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors, backpressure, random traffic,
// counter saturation/clear and mid-flight reset, checked against a queue-based reference model.
module tb_imm_encoder;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    ImmSel;
  logic [31:0]   base_instr;
  logic [31:0]   imm_in;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   instr_out;
  logic          range_err;
  logic          err_clr;
  logic [CW-1:0] err_count;

  imm_encoder #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ImmSel     (ImmSel),
    .base_instr (base_instr),
    .imm_in     (imm_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr_out  (instr_out),
    .range_err  (range_err),
    .err_clr    (err_clr),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          edge_n = 0;
  int          cnt_model = 0;
  bit          last_fin;
  bit          last_fout;
  bit          held = 0;
  logic [31:0] last_instr;
  logic        last_err;

  function automatic logic [31:0] model_pack(input logic [1:0] sel, input logic [31:0] base,
                                             input logic [31:0] imm);
    logic [31:0] mask;
    logic [31:0] field;
    case (sel)
      2'd0: begin
        mask  = 32'hFFF0_0000;
        field = (imm & 32'hFFF) << 20;
      end
      2'd1: begin
        mask  = 32'hFE00_0F80;
        field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      2'd2: begin
        mask  = 32'hFE00_0F80;
        field = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
              | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      end
      default: begin
        mask  = 32'hFFFF_F000;
        field = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
      end
    endcase
    return (base & ~mask) | field;
  endfunction

  function automatic logic model_err(input logic [1:0] sel, input logic [31:0] imm);
    longint v;
    logic   odd;
    v   = longint'($signed(imm));
    odd = imm[0];
    case (sel)
      2'd0, 2'd1: return (v < -2048) || (v > 2047);
      2'd2:       return (v < -4096) || (v > 4095) || odd;
      default:    return (v < -1048576) || (v > 1048575) || odd;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit          exp_rdy;
    bit          exp_vld;
    bit          clr;
    bit          e_fire;
    logic [31:0] w;
    logic        e;
    @(negedge clk);
    exp_rdy = !rst && !(q.size() >= 2 && !out_ready);
    exp_vld = (q.size() > 0) && (q[0].acc < edge_n);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    chk("err_count", 32'(err_count), 32'(cnt_model));
    if (exp_vld) begin
      chk("instr_out", instr_out, q[0].word);
      chk("range_err", 32'(range_err), 32'(q[0].err));
    end
    if (held) begin
      chk("hold_instr", instr_out, last_instr);
      chk("hold_err", 32'(range_err), 32'(last_err));
    end
    held       = out_valid && !out_ready;
    last_instr = instr_out;
    last_err   = range_err;
    last_fin   = in_valid && in_ready;
    last_fout  = out_valid && out_ready;
    w          = model_pack(ImmSel, base_instr, imm_in);
    e          = model_err(ImmSel, imm_in);
    clr        = err_clr;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      q.delete();
      cnt_model = 0;
      held      = 0;
    end else begin
      e_fire = last_fout && (q.size() > 0) && q[0].err;
`ifdef IMMENC_ERRCNT_EN
      if (clr) cnt_model = e_fire ? 1 : 0;
      else if (e_fire && cnt_model < (1 << CW) - 1) cnt_model++;
`endif
      if (last_fout && q.size() > 0) void'(q.pop_front());
      if (last_fin) q.push_back('{w, e, edge_n});
    end
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [31:0] base, input logic [31:0] imm);
    bit got;
    got        = 0;
    in_valid   = 1'b1;
    ImmSel     = sel;
    base_instr = base;
    imm_in     = imm;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      got = last_fin;
    end
    chk("accept_timeout", 32'(got), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) cycle();
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int          sent;
    int          recv;
    bit          pat[8];
    logic [31:0] imm_r;
    rst        = 1'b1;
    in_valid   = 1'b0;
    ImmSel     = 2'b00;
    base_instr = '0;
    imm_in     = '0;
    out_ready  = 1'b1;
    err_clr    = 1'b0;

    // Reset state
    repeat (2) cycle();
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_range_err", 32'(range_err), 32'd0);
    rst = 1'b0;
    cycle();

    // Directed vectors from the format table
    send(2'b00, 32'h0000_0093, 32'hFFFF_FFFF);
    cycle();
    chk("vec_I", instr_out, 32'hFFF0_0093);
    send(2'b01, 32'h0020_A023, 32'h0000_0008);
    cycle();
    chk("vec_S", instr_out, 32'h0020_A423);
    send(2'b10, 32'h0000_0063, 32'hFFFF_FFFC);
    cycle();
    chk("vec_B", instr_out, 32'hFE00_0EE3);
    send(2'b11, 32'h0000_00EF, 32'h0000_0800);
    cycle();
    chk("vec_J", instr_out, 32'h0010_00EF);
    send(2'b11, 32'h0000_00EF, 32'h0000_0801);
    cycle();
    chk("vec_J_misaligned", 32'(range_err), 32'd1);
    send(2'b00, 32'h0000_0093, 32'h0000_0800);
    cycle();
    chk("vec_I_overflow", instr_out, 32'h8000_0093);
    chk("vec_I_overflow_err", 32'(range_err), 32'd1);
    drain();

    // Backpressure: 6 words against a stalling sink
    pat  = '{1, 0, 0, 0, 1, 1, 0, 1};
    sent = 0;
    recv = 0;
    for (int c = 0; c < 80 && (sent < 6 || q.size() > 0); c++) begin
      in_valid   = (sent < 6);
      ImmSel     = 2'(sent);
      base_instr = 32'h0000_1000 * 32'(sent + 1) | 32'h13;
      imm_in     = 32'(sent * 6) - 32'd10;
      out_ready  = pat[c % 8];
      cycle();
      if (last_fin) sent++;
      if (last_fout) recv++;
    end
    in_valid = 1'b0;
    chk("bp_sent", 32'(sent), 32'd6);
    chk("bp_recv", 32'(recv), 32'd6);
    drain();

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      err_clr    = ($urandom_range(0, 15) == 0);
      ImmSel     = 2'($urandom_range(0, 3));
      base_instr = $urandom;
      case ($urandom_range(0, 3))
        0:       imm_r = $urandom;
        1:       imm_r = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:       imm_r = 32'($urandom_range(0, 4095)) - 32'd2048;
        default: imm_r = 32'($urandom_range(0, 2097151)) - 32'h0010_0000;
      endcase
      imm_in = imm_r;
      cycle();
    end
    in_valid = 1'b0;
    err_clr  = 1'b0;
    drain();

    // Saturation: 2^CW+3 erroneous words
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    for (int n = 0; n < (1 << CW) + 3; n++) send(2'b00, 32'h0000_0093, 32'h0000_0800);
    drain();
    cycle();
`ifdef IMMENC_ERRCNT_EN
    chk("sat_count", 32'(err_count), 32'((1 << CW) - 1));
`else
    chk("sat_count", 32'(err_count), 32'd0);
`endif
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    cycle();
    chk("clr_count", 32'(err_count), 32'd0);

    // Clear coinciding with an erroneous transfer leaves exactly one
    send(2'b01, 32'h0, 32'hFFFF_0000);
    drain();
    send(2'b10, 32'h0, 32'h0000_0003);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    cycle();
    send(2'b11, 32'h0, 32'h0020_0000);
    drain();
    cycle();

    // Reset with two words in flight
    out_ready = 1'b0;
    send(2'b00, 32'h13, 32'h0000_0800);
    send(2'b01, 32'h23, 32'h0000_0004);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_instr", instr_out, 32'h0);
    chk("arst_range_err", 32'(range_err), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    cnt_model = 0;
    held      = 0;
    in_valid  = 1'b1;
    repeat (2) cycle();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("post_rst_idle", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
